clk_div_ctrl: RTL and testbench

Parametrised, run-time programmable clock generator for the picoMIPS slow clock. It divides `fastclk` by a loadable half-period and produces a 50 % duty `clk` plus single-cycle edge ticks. Run, halt and single-step modes let the debug front-end freeze or step the processor. Sits between the board oscillator and the picoMIPS core, replacing the fixed power-of-two divider.

---
 rtl/clk_div_ctrl_if.sv | 22 ++
 rtl/clk_div_ctrl.sv | 70 +++++++
 tb/tb_clk_div_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: control/status bundle between the debug front-end and the slow-clock generator.
interface clk_div_ctrl_if #(
  parameter int WIDTH = 12
);
  logic [1:0]       mode;
  logic             div_load;
  logic [WIDTH-1:0] div_val;
  logic             step_req;
  logic             clk;
  logic             rise_tick;
  logic             fall_tick;
  logic             halted;
  logic [WIDTH-1:0] cur_div;
  modport master (
    output mode, div_load, div_val, step_req,
    input  clk, rise_tick, fall_tick, halted, cur_div
  );
  modport slave (
    input  mode, div_load, div_val, step_req,
    output clk, rise_tick, fall_tick, halted, cur_div
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable half-period divider for the picoMIPS slow clock with run/halt/step.
// Step mode and step_req handling exist only when CLKDIV_STEP_EN is defined.
module clk_div_ctrl #(
  parameter int WIDTH       = 12,
  parameter int DEFAULT_DIV = 2048
) (
  input logic            fastclk,
  input logic            reset,
  clk_div_ctrl_if.slave  bus
);
  logic [WIDTH-1:0] r_cnt, r_div_act, r_div_pend;
  logic             r_pend_v, r_clk, r_rise, r_fall, r_halted;
  logic             w_term, w_rise_pt, w_go, w_step_take;
  logic [WIDTH-1:0] w_load_val;
  // a parked block sits on a rising boundary every cycle until released
  assign w_term     = r_halted | (r_cnt == r_div_act - WIDTH'(1));
  assign w_rise_pt  = w_term & ~r_clk;
  assign w_go       = (bus.mode == 2'b00) | w_step_take;
  assign w_load_val = (bus.div_val == '0) ? WIDTH'(1) : bus.div_val;
`ifdef CLKDIV_STEP_EN
  logic r_step_prev, r_step_pend, w_step_mode;
  assign w_step_mode = bus.mode == 2'b10;
  assign w_step_take = w_step_mode & r_step_pend;
  always_ff @(posedge fastclk) begin
    if (reset) begin
      r_step_prev <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      r_step_prev <= bus.step_req;
      r_step_pend <= w_step_mode & ~(w_rise_pt & w_step_take) & (r_step_pend | (bus.step_req & ~r_step_prev));
    end
  end
`else
  logic w_unused;
  assign w_unused    = bus.step_req;
  assign w_step_take = 1'b0;
`endif
  always_ff @(posedge fastclk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_clk      <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_halted   <= 1'b0;
      r_div_act  <= WIDTH'(DEFAULT_DIV);
      r_div_pend <= '0;
      r_pend_v   <= 1'b0;
    end else begin
      r_rise   <= w_rise_pt & w_go;
      r_fall   <= w_term & r_clk;
      r_pend_v <= bus.div_load | (r_pend_v & ~w_rise_pt);
      if (bus.div_load) r_div_pend <= w_load_val;
      if (w_rise_pt & r_pend_v) r_div_act <= r_div_pend;
      if (w_term & (r_clk | w_go)) begin
        r_cnt    <= '0;
        r_clk    <= ~r_clk;
        r_halted <= 1'b0;
      end else if (w_rise_pt) begin
        r_halted <= 1'b1;
      end else begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
    end
  end
  assign bus.clk       = r_clk;
  assign bus.rise_tick = r_rise;
  assign bus.fall_tick = r_fall;
  assign bus.halted    = r_halted;
  assign bus.cur_div   = r_div_act;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench; expected tick edges are queued with the stimulus and popped per tick.
module tb_clk_div_ctrl;
  localparam int WIDTH = 12;
  localparam int DDIV  = 4;
  typedef struct {
    int rise;
    int edge_n;
  } ev_t;
  logic fastclk = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   r0, r2, p;
  ev_t  sb[$];
  clk_div_ctrl_if #(.WIDTH(WIDTH)) bus ();
  clk_div_ctrl #(.WIDTH(WIDTH), .DEFAULT_DIV(DDIV)) dut (
    .fastclk (fastclk),
    .reset   (reset),
    .bus     (bus)
  );
  always #5 fastclk = ~fastclk;
  always @(posedge fastclk) cyc <= cyc + 1;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask
  task automatic exp_ev(input int rise, input int edge_n);
    ev_t e;
    e.rise   = rise;
    e.edge_n = edge_n;
    sb.push_back(e);
  endtask
  task automatic wait_to(input int e);
    while (cyc < e) @(negedge fastclk);
  endtask
  always @(negedge fastclk) begin
    if (bus.rise_tick | bus.fall_tick) begin
      if (sb.size() == 0) check("extra_tick", cyc, -1);
      else begin
        ev_t e;
        e = sb.pop_front();
        check("tick_kind", int'(bus.rise_tick), e.rise);
        check("tick_edge", cyc, e.edge_n);
        check("clk_at_tick", int'(bus.clk), e.rise);
      end
    end
  end
  initial begin
    bus.mode = 2'b00; bus.div_load = 1'b0; bus.div_val = '0; bus.step_req = 1'b0;
    @(negedge fastclk);
    @(negedge fastclk);
    check("rst_clk", bus.clk, 0);
    check("rst_rise", bus.rise_tick, 0);
    check("rst_fall", bus.fall_tick, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_cur_div", bus.cur_div, DDIV);
    reset = 1'b0;
    r0 = cyc;
    exp_ev(1, r0+4);  exp_ev(0, r0+8);  exp_ev(1, r0+12); exp_ev(0, r0+16);
    exp_ev(1, r0+20); exp_ev(0, r0+24); exp_ev(1, r0+31); exp_ev(0, r0+35);
    exp_ev(1, r0+39); exp_ev(0, r0+41); exp_ev(1, r0+43); exp_ev(0, r0+45);
    exp_ev(1, r0+47); exp_ev(0, r0+48); exp_ev(1, r0+49); exp_ev(0, r0+50);
    exp_ev(1, r0+54);
    wait_to(r0+21); bus.mode = 2'b01;
    wait_to(r0+27); check("halt_pre", bus.halted, 0);
    wait_to(r0+28); check("halt_park", bus.halted, 1); check("halt_clk", bus.clk, 0);
    wait_to(r0+30); bus.mode = 2'b00;
    wait_to(r0+31); check("release_halted", bus.halted, 0);
    wait_to(r0+32); bus.div_load = 1'b1; bus.div_val = 12'd2;
    wait_to(r0+33); bus.div_load = 1'b0;
    wait_to(r0+38); check("div_old", bus.cur_div, 4);
    wait_to(r0+39); check("div_new", bus.cur_div, 2);
    wait_to(r0+44); bus.div_load = 1'b1; bus.div_val = 12'd0;
    wait_to(r0+45); bus.div_load = 1'b0;
    wait_to(r0+47); check("div_zero", bus.cur_div, 1);
    wait_to(r0+49); bus.mode = 2'b01;
    wait_to(r0+51); check("halt_div1", bus.halted, 1);
    wait_to(r0+52); bus.div_load = 1'b1; bus.div_val = 12'd3;
    wait_to(r0+53); bus.div_load = 1'b0; bus.mode = 2'b00;
    wait_to(r0+54); check("load_parked", bus.cur_div, 3);
    wait_to(r0+55); bus.div_load = 1'b1; bus.div_val = 12'd7;
    wait_to(r0+56); bus.div_load = 1'b0; reset = 1'b1;
    wait_to(r0+57);
    check("mid_rst_clk", bus.clk, 0);
    check("mid_rst_div", bus.cur_div, DDIV);
    check("mid_rst_fall", bus.fall_tick, 0);
    reset = 1'b0;
    r2 = cyc;
    exp_ev(1, r2+4); exp_ev(0, r2+8); exp_ev(1, r2+12); exp_ev(0, r2+16);
    wait_to(r2+4);  check("no_pend_apply", bus.cur_div, DDIV);
    wait_to(r2+13); bus.mode = 2'b01;
    wait_to(r2+20); check("halt2", bus.halted, 1);
    p = r2 + 21;
`ifdef CLKDIV_STEP_EN
    exp_ev(1, p+4); exp_ev(0, p+8); exp_ev(1, p+12); exp_ev(0, p+16);
`endif
    wait_to(p);   bus.mode = 2'b10;
    wait_to(p+2); bus.step_req = 1'b1;
    wait_to(p+3); bus.step_req = 1'b0; check("step_wait", bus.halted, 1);
    wait_to(p+5); bus.step_req = 1'b1;
    wait_to(p+6); bus.step_req = 1'b0;
    wait_to(p+7); bus.step_req = 1'b1;
    wait_to(p+8); bus.step_req = 1'b0;
`ifdef CLKDIV_STEP_EN
    wait_to(p+11); check("step_low", bus.halted, 0);
`endif
    wait_to(p+20); check("step_park", bus.halted, 1); check("step_park_clk", bus.clk, 0);
    wait_to(p+30);
    check("queue_left", sb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
